// File: rtl/axi_stream_demux_pkg.sv
// Shared types for the frame-locked 1:2 video stream demux.
// FSM state encoding and output select codes.
package axi_stream_demux_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;

  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream video bundle: tdata/tkeep/tlast/tuser(SOF)/tvalid/tready.
// Modport s drives a stream out, modport d receives one.
interface axi4_stream_if #(
  parameter int DW = 32
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic            tuser;
  logic            tvalid;
  logic            tready;

  modport s (
    output tdata, tkeep, tlast, tuser, tvalid,
    input  tready
  );

  modport d (
    input  tdata, tkeep, tlast, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry register slice: s_* in, m_* out, all outputs from flops.
// s_ready drops only while the second (skid) entry is occupied.
module axis_skid_buf #(
  parameter int W = 38
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] s_payload,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_payload,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] m_q;
  logic [W-1:0] skid_q;
  logic         m_v_q;
  logic         skid_v_q;
  logic         s_acc;
  logic         m_free;

  assign s_acc  = s_valid && !skid_v_q;
  assign m_free = !m_v_q || m_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_v_q    <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (m_free) begin
      // skid entry is older than anything arriving now
      if (skid_v_q) begin
        m_v_q    <= 1'b1;
        skid_v_q <= 1'b0;
      end else begin
        m_v_q    <= s_acc;
      end
    end else if (s_acc) begin
      skid_v_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (m_free) begin
      if (skid_v_q) begin
        m_q <= skid_q;
      end else if (s_acc) begin
        m_q <= s_payload;
      end
    end else if (s_acc) begin
      skid_q <= s_payload;
    end
  end

  assign s_ready   = !skid_v_q;
  assign m_payload = m_q;
  assign m_valid   = m_v_q;

endmodule

// File: rtl/axi_stream_demux.sv
// Frame-locked 1:2 AXI4-Stream demux; output select moves only on SOF.
// Ports: clk_i/rst_i, axi_video_i (d), axi_video_out1_o/out2_o (s),
// mux_sel, active_sel_o, frame_cnt1_o/2_o, drop_cnt_o, trunc_cnt_o.
module axi_stream_demux
  import axi_stream_demux_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  axi4_stream_if.d         axi_video_i,
  axi4_stream_if.s         axi_video_out1_o,
  axi4_stream_if.s         axi_video_out2_o,
  input  logic             mux_sel,
  output logic             active_sel_o,
  output logic [CNT_W-1:0] frame_cnt1_o,
  output logic [CNT_W-1:0] frame_cnt2_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [CNT_W-1:0] trunc_cnt_o
);

  localparam int KW = DW / 8;
  localparam int PW = DW + KW + 2;

  state_t           state_q;
  logic             sel_q;
  logic [CNT_W-1:0] f1_q;
  logic [CNT_W-1:0] f2_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] trunc_q;

  logic          dest;
  logic          idle_drop;
  logic          accept;
  logic          rdy1;
  logic          rdy2;
  logic [PW-1:0] in_pl;
  logic [PW-1:0] pl1;
  logic [PW-1:0] pl2;

  // SOF beats go where mux_sel points, even an early SOF in ROUTE
  assign dest      = axi_video_i.tuser ? mux_sel : sel_q;
  assign idle_drop = (state_q == IDLE) && !axi_video_i.tuser;

  always_comb begin
    axi_video_i.tready = 1'b1;
    if (!idle_drop) begin
      axi_video_i.tready = (dest == SEL_OUT2) ? rdy2 : rdy1;
    end
  end

  assign accept = axi_video_i.tvalid && axi_video_i.tready;

  assign in_pl = {axi_video_i.tdata, axi_video_i.tkeep,
                  axi_video_i.tlast, axi_video_i.tuser};

  axis_skid_buf #(.W(PW)) u_buf1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_payload (in_pl),
    .s_valid   (axi_video_i.tvalid && !idle_drop
                && dest == SEL_OUT1),
    .s_ready   (rdy1),
    .m_payload (pl1),
    .m_valid   (axi_video_out1_o.tvalid),
    .m_ready   (axi_video_out1_o.tready)
  );

  axis_skid_buf #(.W(PW)) u_buf2 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_payload (in_pl),
    .s_valid   (axi_video_i.tvalid && !idle_drop
                && dest == SEL_OUT2),
    .s_ready   (rdy2),
    .m_payload (pl2),
    .m_valid   (axi_video_out2_o.tvalid),
    .m_ready   (axi_video_out2_o.tready)
  );

  assign {axi_video_out1_o.tdata, axi_video_out1_o.tkeep,
          axi_video_out1_o.tlast, axi_video_out1_o.tuser} = pl1;
  assign {axi_video_out2_o.tdata, axi_video_out2_o.tkeep,
          axi_video_out2_o.tlast, axi_video_out2_o.tuser} = pl2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= SEL_OUT1;
      f1_q    <= '0;
      f2_q    <= '0;
      drop_q  <= '0;
      trunc_q <= '0;
    end else if (accept) begin
      unique case (1'b1)
        idle_drop: begin
          if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
        end
        default: begin
          if (axi_video_i.tuser) begin
            sel_q <= mux_sel;
            if (mux_sel == SEL_OUT2) f2_q <= f2_q + CNT_W'(1);
            else                     f1_q <= f1_q + CNT_W'(1);
            // any SOF while routing means the prior frame lost its TLAST
            if (state_q == ROUTE && trunc_q != '1)
              trunc_q <= trunc_q + CNT_W'(1);
          end
          state_q <= axi_video_i.tlast ? IDLE : ROUTE;
        end
      endcase
    end
  end

  assign active_sel_o = sel_q;
  assign frame_cnt1_o = f1_q;
  assign frame_cnt2_o = f2_q;
  assign drop_cnt_o   = drop_q;
  assign trunc_cnt_o  = trunc_q;

endmodule

// File: tb/tb_axi_stream_demux.sv
// Testbench for axi_stream_demux: directed steps plus random traffic,
// checked against a frame-level routing model with per-output queues.
module tb_axi_stream_demux;

  localparam int DW    = 32;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mux_sel = 1'b0;
  logic             active_sel;
  logic [CNT_W-1:0] fc1, fc2, dc, tc;

  axi4_stream_if #(.DW(DW)) vin ();
  axi4_stream_if #(.DW(DW)) out1 ();
  axi4_stream_if #(.DW(DW)) out2 ();

  axi_stream_demux #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .axi_video_i      (vin),
    .axi_video_out1_o (out1),
    .axi_video_out2_o (out2),
    .mux_sel          (mux_sel),
    .active_sel_o     (active_sel),
    .frame_cnt1_o     (fc1),
    .frame_cnt2_o     (fc2),
    .drop_cnt_o       (dc),
    .trunc_cnt_o      (tc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: frame-level routing rules
  beat_t       q1[$];
  beat_t       q2[$];
  bit          in_frame = 0;
  bit          cur = 0;
  logic [15:0] e_f1 = 0, e_f2 = 0, e_drop = 0, e_trunc = 0;
  bit          h1_v = 0, h2_v = 0;
  beat_t       h1, h2;

  int r1_pct = 100;
  int r2_pct = 100;

  always @(posedge clk) begin
    #1;
    out1.tready = ($urandom_range(99) < r1_pct);
    out2.tready = ($urandom_range(99) < r2_pct);
  end

  always @(negedge clk) begin
    beat_t g1, g2, b;
    g1 = {out1.tdata, out1.tkeep, out1.tlast, out1.tuser};
    g2 = {out2.tdata, out2.tkeep, out2.tlast, out2.tuser};
    if (rst) begin
      q1.delete(); q2.delete();
      in_frame = 0; cur = 0;
      e_f1 = 0; e_f2 = 0; e_drop = 0; e_trunc = 0;
      h1_v = 0; h2_v = 0;
    end else begin
      if (h1_v) begin
        chk("out1_hold_valid", out1.tvalid, 1);
        chk("out1_hold_data", g1, h1);
      end
      if (h2_v) begin
        chk("out2_hold_valid", out2.tvalid, 1);
        chk("out2_hold_data", g2, h2);
      end
      h1_v = out1.tvalid && !out1.tready; h1 = g1;
      h2_v = out2.tvalid && !out2.tready; h2 = g2;
      if (out1.tvalid && out1.tready) begin
        if (q1.size() == 0) chk("out1_unexpected", 1, 0);
        else chk("out1_beat", g1, q1.pop_front());
      end
      if (out2.tvalid && out2.tready) begin
        if (q2.size() == 0) chk("out2_unexpected", 1, 0);
        else chk("out2_beat", g2, q2.pop_front());
      end
      if (vin.tvalid && !in_frame && !vin.tuser)
        chk("idle_drop_ready", vin.tready, 1);
      if (vin.tvalid && vin.tready) begin
        b = {vin.tdata, vin.tkeep, vin.tlast, vin.tuser};
        if (!in_frame && !b.u) begin
          if (e_drop != 16'hffff) e_drop++;
        end else begin
          if (b.u) begin
            if (in_frame && e_trunc != 16'hffff) e_trunc++;
            cur = mux_sel;
            if (cur) e_f2++; else e_f1++;
          end
          if (cur) q2.push_back(b); else q1.push_back(b);
          in_frame = !b.l;
        end
      end
    end
  end

  task automatic send(input beat_t b, output int waits);
    bit acc;
    waits = 0;
    acc = 0;
    vin.tdata = b.d; vin.tkeep = b.k;
    vin.tlast = b.l; vin.tuser = b.u;
    vin.tvalid = 1;
    while (!acc) begin
      @(negedge clk);
      acc = vin.tready;
      @(posedge clk); #1;
      if (!acc) begin
        waits++;
        if (waits > 200) begin
          chk("send_timeout", 1, 0);
          acc = 1;
        end
      end
    end
    vin.tvalid = 0;
  endtask

  function automatic beat_t mk(input bit u, input bit l);
    beat_t b;
    b.d = $urandom;
    b.k = 4'($urandom);
    b.l = l;
    b.u = u;
    return b;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0 || out1.tvalid
            || out2.tvalid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drain"}, 64'(n < 2000), 1);
    chk({tag, "_fc1"}, fc1, e_f1);
    chk({tag, "_fc2"}, fc2, e_f2);
    chk({tag, "_drop"}, dc, e_drop);
    chk({tag, "_trunc"}, tc, e_trunc);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v1", out1.tvalid, 0);
    chk("rst_v2", out2.tvalid, 0);
    chk("rst_sel", active_sel, 0);
    chk("rst_cnt", {fc1, fc2, dc, tc}, 0);
    rst = 0;
  endtask

  initial begin
    int w;
    int wsum;
    beat_t b;
    vin.tvalid = 0; vin.tdata = 0; vin.tkeep = 0;
    vin.tlast = 0; vin.tuser = 0;
    out1.tready = 1; out2.tready = 1;
    @(posedge clk); #1;
    do_reset();

    // 4-beat frame to out1, one-cycle latency
    mux_sel = 0;
    b = mk(1, 0);
    send(b, w);
    chk("lat_v1", out1.tvalid, 1);
    chk("lat_d1", out1.tdata, b.d);
    chk("lat_v2", out2.tvalid, 0);
    send(mk(0, 0), w);
    send(mk(0, 0), w);
    send(mk(0, 1), w);
    drain("t1");
    chk("t1_fc1_one", fc1, 1);

    // mux_sel toggles mid-frame; takes effect at next SOF
    send(mk(1, 0), w);
    send(mk(0, 0), w);
    mux_sel = 1;
    send(mk(0, 0), w);
    send(mk(0, 1), w);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_sel_hold", active_sel, 0);
    send(mk(1, 0), w);
    chk("t2_sel_new", active_sel, 1);
    send(mk(0, 0), w);
    send(mk(0, 1), w);
    drain("t2");
    chk("t2_fc2_one", fc2, 1);

    // drops while unsynchronised
    do_reset();
    wsum = 0;
    repeat (3) begin
      send(mk(0, 0), w);
      wsum += w;
    end
    chk("t3_drop_nowait", wsum, 0);
    send(mk(1, 0), w);
    send(mk(0, 0), w);
    send(mk(0, 1), w);
    drain("t3");
    chk("t3_drop_three", dc, 3);

    // early SOF at beat 5 re-selects to out2
    mux_sel = 0;
    send(mk(1, 0), w);
    for (int i = 1; i < 5; i++) send(mk(0, 0), w);
    mux_sel = 1;
    send(mk(1, 0), w);
    send(mk(0, 0), w);
    send(mk(0, 1), w);
    drain("t4");
    chk("t4_trunc_one", tc, 1);

    // 64-beat frame with random back-pressure on out1
    mux_sel = 0;
    r1_pct = 50;
    for (int i = 0; i < 64; i++) send(mk(i == 0, i == 63), w);
    drain("t5");
    r1_pct = 100;

    // full-rate streaming, then reset mid-frame
    mux_sel = 1;
    wsum = 0;
    for (int i = 0; i < 20; i++) begin
      send(mk(i == 0, i == 19), w);
      wsum += w;
    end
    chk("t6_fullrate", wsum, 0);
    send(mk(1, 0), w);
    for (int i = 0; i < 4; i++) send(mk(0, 0), w);
    rst = 1;
    @(posedge clk); #1;
    chk("t6_rst_v1", out1.tvalid, 0);
    chk("t6_rst_v2", out2.tvalid, 0);
    chk("t6_rst_cnt", {fc1, fc2, dc, tc}, 0);
    chk("t6_rst_sel", active_sel, 0);
    rst = 0;
    send(mk(0, 0), w);
    drain("t6");
    chk("t6_idle_drop", dc, 1);

    // random mixed traffic with back-pressure on both outputs
    r1_pct = 70;
    r2_pct = 60;
    for (int i = 0; i < 300; i++) begin
      mux_sel = 1'($urandom);
      send(mk($urandom_range(9) == 0, $urandom_range(6) == 0), w);
    end
    drain("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
